// File: rtl/dmac_write_realign.sv
// Byte realigner between the read engine and the write engine: strips src_offset head bytes, inserts dst_offset zero lanes.
// Latency: 1 cycle from an s handshake to m_valid; sustains 1 beat/cycle when both sides are always ready.
// Backpressure: s_ready drops when the 2*BYTES buffer cannot take a full beat; m_data/m_last/m_strb hold while m_valid && !m_ready.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   cfg_valid_i / cfg_ready_o    transfer descriptor handshake (ready only in IDLE)
//   cfg_src_offset_i             source address % BYTES
//   cfg_dst_offset_i             destination address % BYTES
//   cfg_length_i                 transfer length in bytes (0 allowed)
//   s_valid_i/s_ready_o/s_data_i read-data stream, aligned to the source address
//   m_valid_o/m_ready_i/m_data_o realigned stream to the write engine, m_last_o on the final beat
//   m_strb_o                     lane-valid mask, present only with DMAC_WRITE_REALIGN_STRB_EN defined
//   done_o                       1-cycle pulse the cycle after the final m handshake
module dmac_write_realign #(
   parameter  int ADDR_WD = 32,
   parameter  int DATA_WD = 32,
   localparam int BYTES   = DATA_WD / 8,
   localparam int OW      = $clog2(BYTES)
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               cfg_valid_i,
   output logic               cfg_ready_o,
   input  logic [OW-1:0]      cfg_src_offset_i,
   input  logic [OW-1:0]      cfg_dst_offset_i,
   input  logic [ADDR_WD-1:0] cfg_length_i,
   input  logic               s_valid_i,
   output logic               s_ready_o,
   input  logic [DATA_WD-1:0] s_data_i,
   output logic               m_valid_o,
   input  logic               m_ready_i,
   output logic [DATA_WD-1:0] m_data_o,
   output logic               m_last_o,
`ifdef DMAC_WRITE_REALIGN_STRB_EN
   output logic [BYTES-1:0]   m_strb_o,
`endif
   output logic               done_o
);

   localparam int BUFN = 2 * BYTES;
   // Fill counts 0..BUFN; one extra bit lets index sums up to 2*BUFN-1 be formed without wrapping.
   localparam int FW   = $clog2(BUFN) + 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state_q;
   logic [OW-1:0]      src_off_q, dst_off_q;
   logic [ADDR_WD-1:0] in_rem_q;      // source bytes still to accept
   logic [ADDR_WD-1:0] out_bytes_q;   // payload bytes still to emit
   logic [ADDR_WD:0]   out_beats_q;   // output beats still to emit
   logic               first_in_q, first_out_q;
   logic [7:0]         buf_q [BUFN];  // buf_q[0] is the oldest byte
   logic [7:0]         buf_d [BUFN];
   logic [FW-1:0]      fill_q, fill_d, fill_sh;

   logic [OW-1:0]      in_lo, out_lo;
   logic [ADDR_WD-1:0] in_avail, in_n, out_avail, need;
   logic [FW-1:0]      in_n_f, need_f, used_f;
   logic               s_hs, m_hs;

   // Only the first beat on each side is offset; every later beat starts at lane 0.
   assign in_lo     = first_in_q  ? src_off_q : '0;
   assign out_lo    = first_out_q ? dst_off_q : '0;
   assign in_avail  = ADDR_WD'(BYTES) - ADDR_WD'(in_lo);
   assign in_n      = (in_rem_q < in_avail) ? in_rem_q : in_avail;
   assign out_avail = ADDR_WD'(BYTES) - ADDR_WD'(out_lo);
   assign need      = (out_bytes_q < out_avail) ? out_bytes_q : out_avail;
   assign in_n_f    = FW'(in_n);
   assign need_f    = FW'(need);

   assign cfg_ready_o = (state_q == IDLE);
   assign done_o      = (state_q == DONE);
   assign m_valid_o   = (state_q == RUN) && (fill_q >= need_f);
   assign m_last_o    = m_valid_o && (out_beats_q == (ADDR_WD+1)'(1));
   assign m_hs        = m_valid_o && m_ready_i;
   assign used_f      = m_hs ? need_f : '0;
   // Accept only when a full beat fits after this cycle's drain.
   assign s_ready_o   = (state_q == RUN) && (in_rem_q != '0) &&
                        (({1'b0, fill_q} + (FW+1)'(BYTES) - {1'b0, used_f}) <= (FW+1)'(BUFN));
   assign s_hs        = s_valid_i && s_ready_o;

   // Output lanes out_lo..out_lo+need-1 take the oldest buffered bytes; all other lanes are zero.
   always_comb begin
      logic [FW-1:0] k;
      k        = '0;
      m_data_o = '0;
`ifdef DMAC_WRITE_REALIGN_STRB_EN
      m_strb_o = '0;
`endif
      for (int l = 0; l < BYTES; l++) begin
         k = FW'(l) - FW'(out_lo);
         if (m_valid_o && (FW'(l) >= FW'(out_lo)) && (k < need_f)) begin
            m_data_o[8*l +: 8] = buf_q[k[FW-2:0]];
`ifdef DMAC_WRITE_REALIGN_STRB_EN
            m_strb_o[l] = 1'b1;
`endif
         end
      end
   end

   // Next buffer: drop the bytes consumed by this cycle's m handshake, then append the new source lanes.
   always_comb begin
      logic [FW-1:0] idx, pos;
      logic [OW-1:0] lane;
      idx     = '0;
      pos     = '0;
      lane    = '0;
      fill_sh = fill_q - used_f;
      for (int i = 0; i < BUFN; i++) begin
         idx      = FW'(i) + used_f;
         buf_d[i] = (idx < fill_q) ? buf_q[idx[FW-2:0]] : 8'h00;
      end
      for (int i = 0; i < BUFN; i++) begin
         pos = FW'(i) - fill_sh;
         if (s_hs && (FW'(i) >= fill_sh) && (pos < in_n_f)) begin
            lane     = pos[OW-1:0] + in_lo;
            buf_d[i] = s_data_i[8*lane +: 8];
         end
      end
      fill_d = fill_sh + (s_hs ? in_n_f : '0);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         src_off_q   <= '0;
         dst_off_q   <= '0;
         in_rem_q    <= '0;
         out_bytes_q <= '0;
         out_beats_q <= '0;
         first_in_q  <= 1'b0;
         first_out_q <= 1'b0;
         fill_q      <= '0;
         for (int i = 0; i < BUFN; i++) buf_q[i] <= 8'h00;
      end else begin
         for (int i = 0; i < BUFN; i++) buf_q[i] <= buf_d[i];
         case (state_q)
            IDLE: begin
               if (cfg_valid_i) begin
                  src_off_q   <= cfg_src_offset_i;
                  dst_off_q   <= cfg_dst_offset_i;
                  in_rem_q    <= cfg_length_i;
                  out_bytes_q <= cfg_length_i;
                  out_beats_q <= ({1'b0, cfg_length_i} + (ADDR_WD+1)'(cfg_dst_offset_i) +
                                  (ADDR_WD+1)'(BYTES - 1)) >> OW;
                  first_in_q  <= 1'b1;
                  first_out_q <= 1'b1;
                  fill_q      <= '0;
                  state_q     <= (cfg_length_i == '0) ? DONE : RUN;
               end
            end
            RUN: begin
               fill_q <= fill_d;
               if (s_hs) begin
                  in_rem_q   <= in_rem_q - in_n;
                  first_in_q <= 1'b0;
               end
               if (m_hs) begin
                  out_bytes_q <= out_bytes_q - need;
                  out_beats_q <= out_beats_q - (ADDR_WD+1)'(1);
                  first_out_q <= 1'b0;
                  if (m_last_o) state_q <= DONE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmac_write_realign.sv
`timescale 1ns/1ps
module tb_dmac_write_realign;
   localparam int AW = 32;
   localparam int DW = 32;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          cfg_valid_i;
   logic          cfg_ready_o;
   logic [1:0]    cfg_src_offset_i, cfg_dst_offset_i;
   logic [AW-1:0] cfg_length_i;
   logic          s_valid_i, s_ready_o;
   logic [DW-1:0] s_data_i;
   logic          m_valid_o, m_ready_i, m_last_o, done_o;
   logic [DW-1:0] m_data_o;
`ifdef DMAC_WRITE_REALIGN_STRB_EN
   logic [3:0]    m_strb_o;
`endif

   dmac_write_realign #(.ADDR_WD(AW), .DATA_WD(DW)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
      .cfg_src_offset_i(cfg_src_offset_i), .cfg_dst_offset_i(cfg_dst_offset_i),
      .cfg_length_i(cfg_length_i),
      .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_data_i(s_data_i),
      .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_data_o(m_data_o),
      .m_last_o(m_last_o),
`ifdef DMAC_WRITE_REALIGN_STRB_EN
      .m_strb_o(m_strb_o),
`endif
      .done_o(done_o));

   always #5 clk_i = ~clk_i;

   int checks = 0;
   int errors = 0;

   logic [31:0] sbeats[$];    // source beats of the next transfer (random-filled if left empty)
   logic [31:0] dir_data[$];  // optional literal expected m_data beats
   logic [3:0]  dir_strb[$];  // optional literal expected m_strb beats
   bit          mon_done;
   int          extra_acc, s_acc, stab_err, last_mcyc;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cfg_push(input int src, input int dst, input int len);
      bit rdy;
      rdy = 1'b0;
      @(negedge clk_i);
      cfg_valid_i      = 1'b1;
      cfg_src_offset_i = 2'(src);
      cfg_dst_offset_i = 2'(dst);
      cfg_length_i     = AW'(len);
      for (int t = 0; t < 100; t++) begin
         #1 rdy = cfg_ready_o;
         @(posedge clk_i);
         if (rdy) break;
         @(negedge clk_i);
      end
      check("cfg_accept", rdy, 1);
      #1 cfg_valid_i = 1'b0;
   endtask

   // Reference: the output byte stream is dst zero lanes followed by the payload; the payload is the
   // source byte stream with its first src bytes skipped. Both streams are cut into 4-byte beats.
   task automatic run_xfer(input int src, input int dst, input int len, input int gap_pct, input int rdy_pct);
      int nin, nout, q, a;
      logic [31:0] exp_d[$];
      logic [3:0]  exp_s[$];
      logic [31:0] d, w;
      logic [3:0]  s;
      nin  = (len == 0) ? 0 : (src + len + 3) / 4;
      nout = (len == 0) ? 0 : (dst + len + 3) / 4;
      if (sbeats.size() == 0)
         for (int i = 0; i < nin; i++) sbeats.push_back($urandom);
      for (int j = 0; j < nout; j++) begin
         d = '0;
         s = '0;
         for (int l = 0; l < 4; l++) begin
            q = j*4 + l - dst;
            if (q >= 0 && q < len) begin
               a = src + q;
               w = sbeats[a/4];
               d[8*l +: 8] = w[8*(a%4) +: 8];
               s[l] = 1'b1;
            end
         end
         exp_d.push_back(d);
         exp_s.push_back(s);
      end
      cfg_push(src, dst, len);
      mon_done = 0; extra_acc = 0; s_acc = 0; stab_err = 0;
      fork
         begin : drv
            int si, cyc;
            bit sr;
            si = 0; cyc = 0;
            while (!mon_done && cyc < 3000) begin
               @(negedge clk_i);
               if (si < nin) begin
                  s_valid_i = ($urandom_range(99) >= gap_pct);
                  s_data_i  = sbeats[si];
               end else begin
                  s_valid_i = 1'b1;      // extra beat offered: must never be taken
                  s_data_i  = $urandom;
               end
               #1 sr = s_ready_o;
               @(posedge clk_i);
               if (sr && s_valid_i) begin
                  if (si < nin) si++;
                  else extra_acc++;
               end
               cyc++;
            end
            s_acc = si;
            s_valid_i = 1'b0;
         end
         begin : mon
            int j, cyc;
            bit v, r, pv;
            logic [31:0] pd;
            logic pl;
            j = 0; cyc = 0; pv = 0; pd = '0; pl = 0;
            while (j < nout && cyc < 3000) begin
               @(negedge clk_i);
               m_ready_i = ($urandom_range(99) < rdy_pct);
               #1 v = m_valid_o; r = m_ready_i;
               if (pv && (!v || m_data_o !== pd || m_last_o !== pl)) stab_err++;
               if (v && r) begin
                  check("m_data", m_data_o, exp_d[j]);
                  check("m_last", m_last_o, (j == nout - 1));
                  if (j < dir_data.size()) check("m_data_literal", m_data_o, dir_data[j]);
`ifdef DMAC_WRITE_REALIGN_STRB_EN
                  check("m_strb", m_strb_o, exp_s[j]);
                  if (j < dir_strb.size()) check("m_strb_literal", m_strb_o, dir_strb[j]);
`endif
                  j++;
               end
               pv = v && !r; pd = m_data_o; pl = m_last_o;
               @(posedge clk_i);
               cyc++;
            end
            last_mcyc = cyc;
            check("m_beats", j, nout);
            @(negedge clk_i);
            m_ready_i = 1'b0;
            #1;
            check("done_pulse", done_o, 1);
            check("cfg_ready_in_done", cfg_ready_o, 0);
            check("m_valid_after_last", m_valid_o, 0);
            @(negedge clk_i);
            #1;
            check("done_clear", done_o, 0);
            check("cfg_ready_idle", cfg_ready_o, 1);
            mon_done = 1;
         end
      join
      check("s_handshakes", s_acc, nin);
      check("s_extra_accepted", extra_acc, 0);
      check("m_stable_backpressure", stab_err, 0);
      sbeats.delete();
      dir_data.delete();
      dir_strb.delete();
   endtask

   initial begin
      rst_i = 1'b1; cfg_valid_i = 1'b0; cfg_src_offset_i = '0; cfg_dst_offset_i = '0;
      cfg_length_i = '0; s_valid_i = 1'b0; s_data_i = '0; m_ready_i = 1'b0;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b0;
      #1;
      check("rst_cfg_ready", cfg_ready_o, 1);
      check("rst_s_ready", s_ready_o, 0);
      check("rst_m_valid", m_valid_o, 0);
      check("rst_m_last", m_last_o, 0);
      check("rst_done", done_o, 0);
      check("rst_m_data", m_data_o, 0);
`ifdef DMAC_WRITE_REALIGN_STRB_EN
      check("rst_m_strb", m_strb_o, 0);
`endif

      // Aligned copy, both sides always ready.
      sbeats   = '{32'h44332211, 32'h88776655};
      dir_data = '{32'h44332211, 32'h88776655};
      run_xfer(0, 0, 8, 0, 100);
      check("throughput_len8", last_mcyc, 3);

      // Shift right across a beat boundary.
      sbeats   = '{32'h44332211, 32'h88776655};
      dir_data = '{32'h22000000, 32'h66554433, 32'h00000077};
      dir_strb = '{4'b1000, 4'b1111, 4'b0001};
      run_xfer(1, 3, 6, 0, 100);

      // Shift left, tail lane of the second source beat only.
      sbeats   = '{32'hDDCCBBAA, 32'h44332211};
      dir_data = '{32'h332211DD, 32'h00000044};
      run_xfer(3, 0, 5, 0, 100);

      // Zero length: no data movement, done only.
      run_xfer(2, 1, 0, 0, 100);

      // Long transfer with source gaps and random downstream backpressure (17 output beats).
      run_xfer(2, 1, 64, 30, 50);

      // Sustained 1 beat/cycle on an aligned 8-beat transfer.
      run_xfer(0, 0, 32, 0, 100);
      check("throughput_len32", last_mcyc, 9);

      // Reset after 3 of 8 output beats.
      for (int i = 0; i < 8; i++) sbeats.push_back($urandom);
      cfg_push(0, 0, 32);
      begin : rst_step
         int si, mc, cyc;
         bit sr, mv;
         si = 0; mc = 0; cyc = 0;
         while (mc < 3 && cyc < 200) begin
            @(negedge clk_i);
            s_valid_i = 1'b1; s_data_i = sbeats[si]; m_ready_i = 1'b1;
            #1 sr = s_ready_o; mv = m_valid_o;
            @(posedge clk_i);
            if (sr) si++;
            if (mv) mc++;
            cyc++;
         end
         check("pre_reset_m_beats", mc, 3);
      end
      @(negedge clk_i);
      rst_i = 1'b1; s_valid_i = 1'b0; m_ready_i = 1'b0;
      @(negedge clk_i);
      rst_i = 1'b0;
      #1;
      check("midrst_cfg_ready", cfg_ready_o, 1);
      check("midrst_m_valid", m_valid_o, 0);
      check("midrst_s_ready", s_ready_o, 0);
      check("midrst_no_done", done_o, 0);
      sbeats.delete();
      run_xfer(0, 0, 4, 0, 100);

      // Random offsets and lengths, random gaps on both sides.
      for (int t = 0; t < 6; t++)
         run_xfer($urandom_range(3), $urandom_range(3), $urandom_range(40, 1), 25, 60);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
